// File: rtl/fifo_ram_dma_pkg.sv
// Shared types and sizes for the FIFO-to-RAM DMA block.
//   DW        : word width of FIFO and RAM
//   AW        : RAM address width
//   RAM_DEPTH : number of RAM words (2^AW)
//   state_e   : DMA sequencer states
package fifo_ram_dma_pkg;

   localparam int unsigned DW        = 16;
   localparam int unsigned AW        = 7;
   localparam int unsigned RAM_DEPTH = 1 << AW;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      POP  = 3'd1,
      CAPT = 3'd2,
      WR   = 3'd3,
      FIN  = 3'd4
   } state_e;

endpackage

// File: rtl/fifo_ram_dma_ram_wr_arb.sv
// Fixed-priority two-requester RAM write mux; the high-priority side always wins.
//   hi_req/hi_addr/hi_data : high-priority requester (SPI side)
//   lo_req/lo_addr/lo_data : low-priority requester (DMA side)
//   wreq_c/waddr_c/wdata_c : combinational RAM write port
module ram_wr_arb
   import fifo_ram_dma_pkg::*;
#(
   parameter int unsigned DATA_W = DW,
   parameter int unsigned ADDR_W = AW
) (
   input  logic              hi_req,
   input  logic [ADDR_W-1:0] hi_addr,
   input  logic [DATA_W-1:0] hi_data,
   input  logic              lo_req,
   input  logic [ADDR_W-1:0] lo_addr,
   input  logic [DATA_W-1:0] lo_data,
   output logic              wreq_c,
   output logic [ADDR_W-1:0] waddr_c,
   output logic [DATA_W-1:0] wdata_c
);

   always_comb begin
      wreq_c  = lo_req;
      waddr_c = lo_addr;
      wdata_c = lo_data;
      if (hi_req) begin
         wreq_c  = 1'b1;
         waddr_c = hi_addr;
         wdata_c = hi_data;
      end
   end

endmodule

// File: rtl/fifo_ram_dma.sv
// Moves cfg_len words from the SPI write FIFO into RAM starting at cfg_base,
// sharing the RAM write port with the SPI side (SPI has priority).
//   clk, rst_n                    : clock, async active-low reset
//   cfg_start/cfg_abort           : control pulses
//   cfg_base/cfg_len              : transfer setup
//   busy/done/aborted/xfer_cnt    : status
//   fifo_rreq/fifo_rdata/rempty   : FIFO read port (data valid cycle after rreq)
//   spi_wreq/spi_waddr/spi_wdata  : SPI-side RAM write request
//   ram_wreq/ram_waddr/ram_wdata  : muxed RAM write port
module fifo_ram_dma
   import fifo_ram_dma_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_start,
   input  logic          cfg_abort,
   input  logic [AW-1:0] cfg_base,
   input  logic [AW:0]   cfg_len,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [AW:0]   xfer_cnt,
   output logic          fifo_rreq,
   input  logic [DW-1:0] fifo_rdata,
   input  logic          fifo_rempty,
   input  logic          spi_wreq,
   input  logic [AW-1:0] spi_waddr,
   input  logic [DW-1:0] spi_wdata,
   output logic          ram_wreq,
   output logic [AW-1:0] ram_waddr,
   output logic [DW-1:0] ram_wdata
);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   rem_q, rem_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          abrt_q, abrt_d;
   logic [AW:0]   len_eff_c;
   logic          dma_we_c;
   logic          fifo_rreq_c;

   // Lengths beyond the RAM depth would only rewrite the same locations; clamp them.
   always_comb begin
      len_eff_c = cfg_len;
      if (cfg_len > (AW+1)'(RAM_DEPTH)) len_eff_c = (AW+1)'(RAM_DEPTH);
   end

   // Sequencer next-state, datapath updates and combinational strobes.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      abrt_d      = abrt_q;
      dma_we_c    = 1'b0;
      fifo_rreq_c = 1'b0;

      // Abort pre-empts every busy-state action, dropping any popped word.
      if (cfg_abort && (state_q inside {POP, CAPT, WR})) begin
         state_d = FIN;
         abrt_d  = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (cfg_start) begin
                  cnt_d  = '0;
                  abrt_d = 1'b0;
                  if (len_eff_c != '0) begin
                     addr_d  = cfg_base;
                     rem_d   = len_eff_c;
                     state_d = POP;
                  end else begin
                     state_d = FIN;
                  end
               end
            end
            POP: begin
               if (!fifo_rempty) begin
                  fifo_rreq_c = 1'b1;
                  state_d     = CAPT;
               end
            end
            CAPT: begin
               hold_d  = fifo_rdata;
               state_d = WR;
            end
            WR: begin
               if (!spi_wreq) begin
                  dma_we_c = 1'b1;
                  addr_d   = addr_q + AW'(1);
                  cnt_d    = cnt_q + (AW+1)'(1);
                  rem_d    = rem_q - (AW+1)'(1);
                  state_d  = (rem_q == (AW+1)'(1)) ? FIN : POP;
               end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      busy_d = state_d inside {POP, CAPT, WR};
      done_d = (state_d == FIN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abrt_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abrt_q  <= abrt_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign aborted   = abrt_q;
   assign xfer_cnt  = cnt_q;
   assign fifo_rreq = fifo_rreq_c;

   ram_wr_arb #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) u_arb (
      .hi_req  (spi_wreq),
      .hi_addr (spi_waddr),
      .hi_data (spi_wdata),
      .lo_req  (dma_we_c),
      .lo_addr (addr_q),
      .lo_data (hold_q),
      .wreq_c  (ram_wreq),
      .waddr_c (ram_waddr),
      .wdata_c (ram_wdata)
   );

endmodule

// File: tb/tb_fifo_ram_dma.sv
// Directed self-checking bench for fifo_ram_dma with a behavioural FIFO and RAM.
module tb_fifo_ram_dma;
   import fifo_ram_dma_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_start, cfg_abort;
   logic [AW-1:0] cfg_base;
   logic [AW:0]   cfg_len;
   logic          busy, done, aborted;
   logic [AW:0]   xfer_cnt;
   logic          fifo_rreq;
   logic [DW-1:0] fifo_rdata;
   logic          fifo_rempty;
   logic          spi_wreq;
   logic [AW-1:0] spi_waddr;
   logic [DW-1:0] spi_wdata;
   logic          ram_wreq;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] ram_m [128];

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int rreq_cnt = 0;
   int dma_cnt = 0;
   int viol = 0;
   bit busy_seen = 1'b0;

   always #5 clk = ~clk;

   fifo_ram_dma dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .cfg_base(cfg_base), .cfg_len(cfg_len),
      .busy(busy), .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt),
      .fifo_rreq(fifo_rreq), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
      .spi_wreq(spi_wreq), .spi_waddr(spi_waddr), .spi_wdata(spi_wdata),
      .ram_wreq(ram_wreq), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample DUT outputs before the edge, then update FIFO/RAM models after it.
   task automatic step();
      logic          rq, wr, spi;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      #1;
      rq  = fifo_rreq;
      wr  = ram_wreq;
      wa  = ram_waddr;
      wd  = ram_wdata;
      spi = spi_wreq;
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (rq) rreq_cnt++;
      if (rq && fifo_rempty) viol++;
      if (wr && !spi) dma_cnt++;
      if (rq && wr && !spi) viol++;
      @(posedge clk);
      #1;
      if (wr) ram_m[wa] = wd;
      if (rq && fq.size() > 0) fifo_rdata = fq.pop_front();
      fifo_rempty = (fq.size() == 0);
      @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] v);
      fq.push_back(v);
      fifo_rempty = 1'b0;
   endtask

   task automatic start(input logic [AW-1:0] base, input logic [AW:0] len);
      cfg_base  = base;
      cfg_len   = len;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int max, input string tag);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < max) begin
         step();
         n++;
      end
      check({tag, "_timeout"}, 32'(done_cnt != d0), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, r0, w0;
      rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
      cfg_base = '0; cfg_len = '0;
      fifo_rdata = '0; fifo_rempty = 1'b1;
      spi_wreq = 1'b0; spi_waddr = '0; spi_wdata = '0;
      for (int i = 0; i < 128; i++) ram_m[i] = '0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_busy",     32'(busy),      32'd0);
      check("rst_done",     32'(done),      32'd0);
      check("rst_aborted",  32'(aborted),   32'd0);
      check("rst_xfer_cnt", 32'(xfer_cnt),  32'd0);
      check("rst_rreq",     32'(fifo_rreq), 32'd0);
      check("rst_ram_wreq", 32'(ram_wreq),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Basic 5-word transfer to base 10.
      for (int i = 0; i < 5; i++) push(16'(16'hA000 + i));
      d0 = done_cnt;
      start(7'd10, 8'd5);
      wait_done(100, "t1");
      step();
      for (int i = 0; i < 5; i++)
         check($sformatf("t1_ram%0d", 10 + i), 32'(ram_m[10 + i]), 32'(16'hA000 + i));
      check("t1_done_once", 32'(done_cnt - d0), 32'd1);
      check("t1_xfer_cnt",  32'(xfer_cnt),      32'd5);
      check("t1_aborted",   32'(aborted),       32'd0);
      check("t1_fifo_empty", 32'(fq.size()),    32'd0);
      check("t1_busy_low",  32'(busy),          32'd0);

      // Address wrap from 126.
      for (int i = 1; i <= 4; i++) push(16'(i));
      start(7'd126, 8'd4);
      wait_done(100, "t2");
      step();
      check("t2_ram126", 32'(ram_m[126]), 32'd1);
      check("t2_ram127", 32'(ram_m[127]), 32'd2);
      check("t2_ram0",   32'(ram_m[0]),   32'd3);
      check("t2_ram1",   32'(ram_m[1]),   32'd4);

      // FIFO underrun stall in POP.
      push(16'hB001);
      r0 = rreq_cnt;
      start(7'd20, 8'd3);
      repeat (8) step();
      check("t3_stall_busy", 32'(busy),          32'd1);
      check("t3_stall_cnt",  32'(xfer_cnt),      32'd1);
      check("t3_stall_rreq", 32'(rreq_cnt - r0), 32'd1);
      push(16'hB002);
      push(16'hB003);
      wait_done(100, "t3");
      step();
      check("t3_xfer_cnt", 32'(xfer_cnt),  32'd3);
      check("t3_ram22",    32'(ram_m[22]), 32'h0000B003);

      // SPI holds the RAM port while DMA sits in WR.
      push(16'hC0DE);
      w0 = dma_cnt;
      start(7'd40, 8'd1);
      step();
      step();
      spi_wreq = 1'b1; spi_waddr = 7'd50; spi_wdata = 16'h5555;
      repeat (4) step();
      check("t4_stall_nodma",  32'(dma_cnt - w0), 32'd0);
      check("t4_spi_written",  32'(ram_m[50]),    32'h00005555);
      check("t4_dma_pending",  32'(ram_m[40]),    32'd0);
      check("t4_stall_busy",   32'(busy),         32'd1);
      spi_wreq = 1'b0;
      wait_done(20, "t4");
      step();
      check("t4_dma_data",  32'(ram_m[40]),    32'h0000C0DE);
      check("t4_dma_once",  32'(dma_cnt - w0), 32'd1);
      check("t4_xfer_cnt",  32'(xfer_cnt),     32'd1);
      check("t4_spi_kept",  32'(ram_m[50]),    32'h00005555);

      // Abort in CAPT of the third word.
      for (int i = 0; i < 6; i++) push(16'(16'hD000 + i));
      r0 = rreq_cnt;
      d0 = done_cnt;
      start(7'd60, 8'd6);
      repeat (7) step();
      cfg_abort = 1'b1;
      step();
      cfg_abort = 1'b0;
      wait_done(10, "t5");
      step();
      check("t5_done_once", 32'(done_cnt - d0), 32'd1);
      check("t5_aborted",   32'(aborted),       32'd1);
      check("t5_xfer_cnt",  32'(xfer_cnt),      32'd2);
      check("t5_pops",      32'(rreq_cnt - r0), 32'd3);
      check("t5_ram61",     32'(ram_m[61]),     32'h0000D001);
      check("t5_ram62",     32'(ram_m[62]),     32'd0);
      check("t5_fifo_left", 32'(fq.size()),     32'd3);
      fq.delete();
      fifo_rempty = 1'b1;

      // Zero-length start.
      d0 = done_cnt;
      r0 = rreq_cnt;
      busy_seen = 1'b0;
      start(7'd5, 8'd0);
      step();
      check("t6_done_next", 32'(done_cnt - d0), 32'd1);
      step();
      check("t6_done_once", 32'(done_cnt - d0), 32'd1);
      check("t6_no_busy",   32'(busy_seen),     32'd0);
      check("t6_no_rreq",   32'(rreq_cnt - r0), 32'd0);
      check("t6_xfer_clr",  32'(xfer_cnt),      32'd0);

      // Start while busy is ignored.
      push(16'hE000);
      push(16'hE001);
      d0 = done_cnt;
      start(7'd70, 8'd2);
      step();
      start(7'd90, 8'd5);
      wait_done(50, "t7");
      step();
      check("t7_xfer_cnt", 32'(xfer_cnt),       32'd2);
      check("t7_ram70",    32'(ram_m[70]),      32'h0000E000);
      check("t7_ram71",    32'(ram_m[71]),      32'h0000E001);
      check("t7_ram90",    32'(ram_m[90]),      32'd0);
      check("t7_done_once", 32'(done_cnt - d0), 32'd1);

      // Start and abort together in IDLE: start wins.
      push(16'hF00D);
      cfg_abort = 1'b1;
      start(7'd80, 8'd1);
      cfg_abort = 1'b0;
      wait_done(20, "t8");
      step();
      check("t8_aborted",  32'(aborted),   32'd0);
      check("t8_xfer_cnt", 32'(xfer_cnt),  32'd1);
      check("t8_ram80",    32'(ram_m[80]), 32'h0000F00D);

      check("invariants", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_ram_dma.md
Name: fifo_ram_dma

Overview:
Moves a programmed number of 16-bit words from the SPI-side write FIFO into the dual-port RAM, starting at a programmed base address. It sits between fpga_fifo's read port and fpga_ram's write port. It also arbitrates the RAM write port between itself and the SPI interface, and the SPI interface always wins. Start, length and base address come from SPI-written registers; status goes back to an SPI-readable register.

Parameters:
DW  16  data width of FIFO and RAM words
AW  7  RAM address width (depth 2^AW = 128)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_start  in  1  single-cycle start pulse
cfg_abort  in  1  single-cycle abort pulse
cfg_base  in  AW  first RAM address
cfg_len  in  AW+1  words to move, 0..128
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at completion or abort
aborted  out  1  sticky; set when the last transfer ended by abort
xfer_cnt  out  AW+1  words written to RAM in the current or last transfer
fifo_rreq  out  1  FIFO read request
fifo_rdata  in  DW  FIFO read data, valid the cycle after fifo_rreq
fifo_rempty  in  1  FIFO empty flag
spi_wreq  in  1  SPI-side RAM write request
spi_waddr  in  AW  SPI-side RAM write address
spi_wdata  in  DW  SPI-side RAM write data
ram_wreq  out  1  muxed RAM write enable
ram_waddr  out  AW  muxed RAM write address
ram_wdata  out  DW  muxed RAM write data

Behaviour:
- Reset values: busy=0, done=0, aborted=0, xfer_cnt=0, fifo_rreq=0. All internal registers clear; state=IDLE.
- RAM mux is combinational:
  - spi_wreq=1: ram_* = spi_* (SPI has priority).
  - otherwise: ram_* = DMA write signals, and ram_wreq = dma_we.
- States: IDLE, POP, CAPT, WR, FIN.
- IDLE:
  - cfg_start with cfg_len!=0: latch base into addr and len into remaining, clear xfer_cnt and aborted, set busy, go to POP.
  - cfg_start with cfg_len=0: pulse done the next cycle; busy stays 0; xfer_cnt is cleared.
- POP: if !fifo_rempty, assert fifo_rreq for exactly one cycle and go to CAPT. If empty, stay and keep fifo_rreq=0; no timeout.
- CAPT: register fifo_rdata into the hold register, go to WR.
- WR:
  - dma_we = !spi_wreq. If spi_wreq=1, stall in WR with data held; there is no limit on the stall.
  - When the write is granted: addr <= addr+1 (wraps 127->0 modulo 2^AW), xfer_cnt++, remaining--.
  - Then go to FIN if remaining reaches 0, else go to POP.
- FIN: busy=0 and done=1 for this single cycle, go to IDLE.
- Throughput is at best one word per 3 cycles.
- cfg_start while busy is ignored.
- cfg_abort while busy:
  - Takes priority over every transition; go to FIN and set aborted.
  - A word already popped (CAPT, or stalled in WR) is dropped and not written.
  - No fifo_rreq is issued in the abort cycle.
- cfg_abort in IDLE is ignored.
- cfg_start and cfg_abort in the same IDLE cycle: the start wins.
- Asynchronous reset mid-transfer returns to IDLE. FIFO contents are not restored.
- fifo_rreq is never asserted while fifo_rempty=1. dma_we and fifo_rreq are never high in the same cycle.

Decomposition:
- Shared package holds:
  - state enum (IDLE/POP/CAPT/WR/FIN);
  - DW/AW defaults;
  - RAM depth constant.
- One sub-module is natural: ram_wr_arb, the fixed-priority two-requester RAM write mux, reusable when more requesters are added.
- The FSM and counters stay in the top level.

Test Plan:
- FIFO preloaded with 0xA000..0xA004, base=10, len=5, start: RAM[10..14]=0xA000..0xA004; done pulses once; xfer_cnt=5; aborted=0; the FIFO ends empty.
- base=126, len=4, data 1..4: RAM[126]=1, RAM[127]=2, RAM[0]=3, RAM[1]=4 (address wrap).
- len=3 with only 1 word in the FIFO: DMA stalls in POP with busy=1 and xfer_cnt=1. Push 2 more words: transfer completes with xfer_cnt=3.
- spi_wreq held high for 4 cycles while DMA is in WR: the SPI write lands on RAM first; the DMA write lands after the release with its data unchanged; no word is lost or duplicated.
- Abort issued in CAPT after 2 words are written (len=6): done pulses, aborted=1, xfer_cnt=2, exactly 3 words are popped, the third RAM location is unchanged.
- start with len=0: done pulses the next cycle, busy never rises, no fifo_rreq. A start issued while busy is ignored (the original transfer's len is kept).
